// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI master slice.
//   spi_state_t : controller state encoding (IDLE -> SHIFT -> DONE -> IDLE)
//   calc_half() : number of system clocks per SPI half-period (integer floor)
// -----------------------------------------------------------------------------
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } spi_state_t;

    // Half-period length in system clocks. A result below 1 means the SPI
    // clock cannot be generated and is rejected at elaboration by the top.
    function automatic int calc_half(input int clk_freq, input int spi_freq);
        return clk_freq / (2 * spi_freq);
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// -----------------------------------------------------------------------------
// spi_clk_gen
// Half-period counter and edge counter for one SPI transfer.
//   sclk      in   system clock
//   rst_n     in   asynchronous reset, active high
//   en        in   high while the controller is shifting; low clears counters
//   spi_clk   out  SPI serial clock, idles at CPOL
//   lead      out  strobe: spi_clk leaves CPOL at this sclk edge
//   trail     out  strobe: spi_clk returns to CPOL at this sclk edge
//   last_edge out  strobe: this is the final (2*DATA_WIDTH-th) toggle
//   end_tick  out  strobe: one half-period after the final toggle
// Strobes are combinational and qualify the sclk edge at which the matching
// spi_clk change is registered, so the controller acts on the same edge.
// -----------------------------------------------------------------------------
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int HALF       = 5,
    parameter int DATA_WIDTH = 8,
    parameter int CPOL       = 1
) (
    input  logic sclk,
    input  logic rst_n,
    input  logic en,
    output logic spi_clk,
    output logic lead,
    output logic trail,
    output logic last_edge,
    output logic end_tick
);

    localparam int   EDGES    = 2 * DATA_WIDTH;
    localparam int   CW       = $clog2(HALF + 1);
    localparam int   EW       = $clog2(EDGES + 1);
    localparam logic IDLE_LVL = 1'(CPOL);

    logic [CW-1:0] half_cnt;
    logic [EW-1:0] edge_cnt;   // number of half-period ticks already taken
    logic          tick;

    assign tick      = en && (half_cnt == CW'(HALF - 1));
    // Even tick index (0-based) is a leading edge, odd is trailing; the tick
    // after the last toggle only closes the transfer.
    assign lead      = tick && !edge_cnt[0] && (edge_cnt < EW'(EDGES));
    assign trail     = tick && edge_cnt[0];
    assign last_edge = tick && (edge_cnt == EW'(EDGES - 1));
    assign end_tick  = tick && (edge_cnt == EW'(EDGES));

    always_ff @(posedge sclk or posedge rst_n) begin
        if (rst_n) begin
            half_cnt <= '0;
            edge_cnt <= '0;
            spi_clk  <= IDLE_LVL;
        end else if (!en) begin
            half_cnt <= '0;
            edge_cnt <= '0;
            spi_clk  <= IDLE_LVL;
        end else begin
            if (tick) half_cnt <= '0;
            else      half_cnt <= half_cnt + CW'(1);
            if (tick && !end_tick) edge_cnt <= edge_cnt + EW'(1);
            if (lead || trail)     spi_clk  <= ~spi_clk;
        end
    end

endmodule

// File: rtl/spi_master.sv
// -----------------------------------------------------------------------------
// spi_master
// Full-duplex MSB-first SPI master, one DATA_WIDTH-bit transfer per start.
//   sclk      in   system clock (rising edge)
//   rst_n     in   asynchronous reset, active high
//   data_in   in   transmit word, captured when start is accepted
//   start     in   transfer request, accepted only in IDLE
//   miso      in   serial data from slave
//   spi_clk   out  SPI clock (idle = CPOL)
//   cs_n      out  slave select, active low
//   mosi      out  serial data to slave
//   finish    out  one-cycle pulse at transfer end
//   data_out  out  last received word, updated in the finish cycle
// Handshake: start is a level request sampled on each sclk edge while IDLE;
// it is ignored in SHIFT and DONE (nothing is queued). finish pulses for one
// cycle in DONE with data_out already valid; a start sampled on the next edge
// begins a new transfer immediately.
// -----------------------------------------------------------------------------
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_FREQUENCE = 50_000_000,
    parameter int SPI_FREQUENCE = 5_000_000,
    parameter int DATA_WIDTH    = 8,
    parameter int CPOL          = 1,
    parameter int CPHA          = 1
) (
    input  logic                  sclk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  start,
    input  logic                  miso,
    output logic                  spi_clk,
    output logic                  cs_n,
    output logic                  mosi,
    output logic                  finish,
    output logic [DATA_WIDTH-1:0] data_out
);

    localparam int HALF = calc_half(CLK_FREQUENCE, SPI_FREQUENCE);

    generate
        if (HALF < 1) begin : g_half_check
            $error("spi_master: CLK_FREQUENCE/(2*SPI_FREQUENCE) must be at least 1");
        end
    endgenerate

    spi_state_t            state;
    logic [DATA_WIDTH-1:0] tx_sr;
    logic [DATA_WIDTH-1:0] rx_sr;
    logic                  shift_en;
    logic                  lead;
    logic                  trail;
    logic                  last_edge;
    logic                  end_tick;
    logic                  sample_edge;
    logic                  shift_edge;

    assign shift_en = (state == SHIFT);

    spi_clk_gen #(
        .HALF       (HALF),
        .DATA_WIDTH (DATA_WIDTH),
        .CPOL       (CPOL)
    ) u_clk_gen (
        .sclk      (sclk),
        .rst_n     (rst_n),
        .en        (shift_en),
        .spi_clk   (spi_clk),
        .lead      (lead),
        .trail     (trail),
        .last_edge (last_edge),
        .end_tick  (end_tick)
    );

    // CPHA=0 presents the MSB before the first edge, so the final trailing
    // edge must not advance mosi past the LSB. CPHA=1 presents every bit,
    // including the MSB, on a leading edge.
    assign sample_edge = (CPHA != 0) ? trail : lead;
    assign shift_edge  = (CPHA != 0) ? lead  : (trail && !last_edge);

    always_ff @(posedge sclk or posedge rst_n) begin
        if (rst_n) begin
            state    <= IDLE;
            tx_sr    <= '0;
            rx_sr    <= '0;
            cs_n     <= 1'b1;
            mosi     <= 1'b0;
            finish   <= 1'b0;
            data_out <= '0;
        end else begin
            finish <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        cs_n  <= 1'b0;
                        rx_sr <= '0;
                        // tx_sr always holds the bits still to be presented,
                        // MSB-aligned.
                        if (CPHA != 0) begin
                            tx_sr <= data_in;
                            mosi  <= 1'b0;
                        end else begin
                            tx_sr <= data_in << 1;
                            mosi  <= data_in[DATA_WIDTH-1];
                        end
                    end
                end
                SHIFT: begin
                    if (shift_edge) begin
                        mosi  <= tx_sr[DATA_WIDTH-1];
                        tx_sr <= tx_sr << 1;
                    end
                    if (sample_edge) begin
                        rx_sr <= (rx_sr << 1) | DATA_WIDTH'(miso);
                    end
                    if (end_tick) begin
                        state    <= DONE;
                        cs_n     <= 1'b1;
                        mosi     <= 1'b0;
                        finish   <= 1'b1;
                        data_out <= rx_sr;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_spi_master
// Four spi_master instances, one per SPI mode (index = CPOL*2 + CPHA), all at
// the default 50 MHz / 5 MHz ratio (5 system clocks per half-period).
// -----------------------------------------------------------------------------
module tb_spi_master;

    localparam int HALF   = 5;
    localparam int W      = 8;
    localparam int CS_LOW = (2 * W + 1) * HALF;   // 85
    localparam int FIN_AT = CS_LOW + 1;           // finish seen in cycle 86

    // ---------------- clock / reset ----------------
    logic sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic                rst_n;
    logic [7:0]          data_in;
    logic [3:0]          start_v;
    logic [3:0]          miso_v;
    logic [3:0]          spi_clk_v;
    logic [3:0]          cs_n_v;
    logic [3:0]          mosi_v;
    logic [3:0]          finish_v;
    logic [3:0][7:0]     data_out_v;
    logic [3:0]          loop_v;
    logic [3:0]          slave_bit_v;
    logic [7:0]          exp_prev [4];

    assign miso_v = (loop_v & mosi_v) | (~loop_v & slave_bit_v);

    spi_master #(.CPOL(0), .CPHA(0)) u_m0 (
        .sclk(sclk), .rst_n(rst_n), .data_in(data_in), .start(start_v[0]),
        .miso(miso_v[0]), .spi_clk(spi_clk_v[0]), .cs_n(cs_n_v[0]),
        .mosi(mosi_v[0]), .finish(finish_v[0]), .data_out(data_out_v[0]));
    spi_master #(.CPOL(0), .CPHA(1)) u_m1 (
        .sclk(sclk), .rst_n(rst_n), .data_in(data_in), .start(start_v[1]),
        .miso(miso_v[1]), .spi_clk(spi_clk_v[1]), .cs_n(cs_n_v[1]),
        .mosi(mosi_v[1]), .finish(finish_v[1]), .data_out(data_out_v[1]));
    spi_master #(.CPOL(1), .CPHA(0)) u_m2 (
        .sclk(sclk), .rst_n(rst_n), .data_in(data_in), .start(start_v[2]),
        .miso(miso_v[2]), .spi_clk(spi_clk_v[2]), .cs_n(cs_n_v[2]),
        .mosi(mosi_v[2]), .finish(finish_v[2]), .data_out(data_out_v[2]));
    spi_master u_m3 (
        .sclk(sclk), .rst_n(rst_n), .data_in(data_in), .start(start_v[3]),
        .miso(miso_v[3]), .spi_clk(spi_clk_v[3]), .cs_n(cs_n_v[3]),
        .mosi(mosi_v[3]), .finish(finish_v[3]), .data_out(data_out_v[3]));

    // ---------------- scoreboard counters ----------------
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // ---------------- driver: one transfer with monitoring ----------------
    task automatic run_xfer(input int sel, input logic [7:0] din, input logic [7:0] sw,
                            input logic lp, input logic [7:0] exp_do,
                            input int hold_from, input int hold_len);
        logic       cpol, cpha, prev_clk, lead;
        logic [7:0] sr, mosi_cap, prev_do;
        int         cyc, cs_low, toggles, last_tog, bad_gap, early_mosi, do_changed, finish_cyc;
        bit         got_finish;
        string      tag;
        cpol = sel[1];
        cpha = sel[0];
        tag  = $sformatf("m%0d_%02h", sel, din);
        prev_do = exp_prev[sel];

        @(negedge sclk);
        check($sformatf("%s_idle_clk", tag),    spi_clk_v[sel], cpol);
        check($sformatf("%s_idle_cs", tag),     cs_n_v[sel], 1'b1);
        check($sformatf("%s_idle_mosi", tag),   mosi_v[sel], 1'b0);
        check($sformatf("%s_idle_finish", tag), finish_v[sel], 1'b0);
        check($sformatf("%s_held_dout", tag),   data_out_v[sel], prev_do);

        loop_v[sel]      = lp;
        sr               = sw;
        slave_bit_v[sel] = cpha ? 1'b0 : sr[7];
        data_in          = din;
        start_v[sel]     = 1'b1;
        @(posedge sclk);   // T0: request accepted here

        cyc = 0; cs_low = 0; toggles = 0; last_tog = 1; bad_gap = 0;
        early_mosi = 0; do_changed = 0; finish_cyc = 0; got_finish = 0;
        mosi_cap = '0; prev_clk = cpol;
        while (!got_finish && cyc < 200) begin
            @(negedge sclk);
            cyc++;
            start_v[sel] = (cyc >= hold_from) && (cyc < hold_from + hold_len);
            if (cyc == 1) begin
                data_in = ~din;
                check($sformatf("%s_cs_fall_T1", tag), cs_n_v[sel], 1'b0);
            end
            if (!cs_n_v[sel]) cs_low++;
            if (spi_clk_v[sel] != prev_clk) begin
                toggles++;
                if (cyc - last_tog != HALF) bad_gap++;
                last_tog = cyc;
                lead     = (spi_clk_v[sel] != cpol);
                prev_clk = spi_clk_v[sel];
                if (cpha ? !lead : lead) mosi_cap = {mosi_cap[6:0], mosi_v[sel]};
                // Slave model: CPHA=0 changes data on trailing edges, CPHA=1 on leading.
                if (cpha && lead) begin
                    slave_bit_v[sel] = sr[7];
                    sr = sr << 1;
                end else if (!cpha && !lead) begin
                    sr = sr << 1;
                    slave_bit_v[sel] = sr[7];
                end
            end
            if (cpha && toggles == 0 && mosi_v[sel] !== 1'b0) early_mosi++;
            if (finish_v[sel]) begin
                got_finish = 1;
                finish_cyc = cyc;
            end else if (data_out_v[sel] !== prev_do) begin
                do_changed++;
            end
        end
        start_v[sel] = 1'b0;

        check($sformatf("%s_finish_seen", tag),  got_finish, 1'b1);
        check($sformatf("%s_finish_cycle", tag), finish_cyc, FIN_AT);
        check($sformatf("%s_cs_low_cycles", tag), cs_low, CS_LOW);
        check($sformatf("%s_toggles", tag),      toggles, 2 * W);
        check($sformatf("%s_bad_gaps", tag),     bad_gap, 0);
        check($sformatf("%s_mosi_bits", tag),    mosi_cap, din);
        check($sformatf("%s_early_mosi", tag),   early_mosi, 0);
        check($sformatf("%s_dout_stable", tag),  do_changed, 0);
        check($sformatf("%s_data_out", tag),     data_out_v[sel], exp_do);
        check($sformatf("%s_end_clk", tag),      spi_clk_v[sel], cpol);
        check($sformatf("%s_end_cs", tag),       cs_n_v[sel], 1'b1);
        check($sformatf("%s_end_mosi", tag),     mosi_v[sel], 1'b0);
        exp_prev[sel] = exp_do;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int         sel;      // CPOL*2 + CPHA
        logic [7:0] din;
        logic [7:0] sw;       // word shifted out by the slave model
        logic       lp;       // 1 = miso looped from mosi
        logic [7:0] exp_do;
    } vec_t;

    vec_t vecs [6];

    initial begin : main
        int viol;
        int cyc;
        int toggles;
        int fin_cnt;
        logic prev;

        rst_n = 1'b1; data_in = '0; start_v = '0; loop_v = '0; slave_bit_v = '0;
        for (int i = 0; i < 4; i++) exp_prev[i] = 8'h00;

        vecs[0] = '{3, 8'hA5, 8'h00, 1'b1, 8'hA5};   // mode 3 loopback
        vecs[1] = '{3, 8'h9A, 8'h00, 1'b1, 8'h9A};   // back-to-back after vecs[0]
        vecs[2] = '{0, 8'hC3, 8'h3C, 1'b0, 8'h3C};   // mode 0, slave sends 0x3C
        vecs[3] = '{2, 8'h5A, 8'h00, 1'b1, 8'h5A};   // mode 2 loopback
        vecs[4] = '{1, 8'h5A, 8'h00, 1'b1, 8'h5A};   // mode 1 loopback
        vecs[5] = '{1, 8'h7E, 8'h81, 1'b0, 8'h81};   // mode 1, slave sends 0x81

        repeat (3) @(negedge sclk);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_clk_m%0d", i),  spi_clk_v[i], i[1]);
            check($sformatf("rst_cs_m%0d", i),   cs_n_v[i], 1'b1);
            check($sformatf("rst_mosi_m%0d", i), mosi_v[i], 1'b0);
            check($sformatf("rst_fin_m%0d", i),  finish_v[i], 1'b0);
            check($sformatf("rst_dout_m%0d", i), data_out_v[i], 8'h00);
        end
        rst_n = 1'b0;
        repeat (2) @(negedge sclk);

        for (int v = 0; v < 6; v++)
            run_xfer(vecs[v].sel, vecs[v].din, vecs[v].sw, vecs[v].lp, vecs[v].exp_do, 0, 0);

        // start held high for 40 cycles in the middle of a transfer
        run_xfer(3, 8'h3C, 8'h00, 1'b1, 8'h3C, 20, 40);
        viol = 0;
        repeat (50) begin
            @(negedge sclk);
            if (!cs_n_v[3] || finish_v[3]) viol++;
        end
        check("hold_start_no_restart", viol, 0);

        // reset asserted at the 7th spi_clk toggle of a mode 3 transfer
        @(negedge sclk);
        data_in = 8'hFF; loop_v[3] = 1'b1; start_v[3] = 1'b1;
        @(negedge sclk);
        start_v[3] = 1'b0;
        toggles = 0; cyc = 0; prev = spi_clk_v[3];
        while (toggles < 7 && cyc < 200) begin
            @(negedge sclk);
            cyc++;
            if (spi_clk_v[3] != prev) begin
                toggles++;
                prev = spi_clk_v[3];
            end
        end
        check("abort_reach_toggle7", toggles, 7);
        rst_n = 1'b1;
        #1;
        check("abort_cs",   cs_n_v[3], 1'b1);
        check("abort_clk",  spi_clk_v[3], 1'b1);
        check("abort_mosi", mosi_v[3], 1'b0);
        check("abort_fin",  finish_v[3], 1'b0);
        check("abort_dout", data_out_v[3], 8'h00);
        fin_cnt = 0;
        repeat (5) begin
            @(negedge sclk);
            if (finish_v != 4'b0000) fin_cnt++;
        end
        rst_n = 1'b0;
        repeat (5) begin
            @(negedge sclk);
            if (finish_v != 4'b0000) fin_cnt++;
        end
        check("abort_no_finish", fin_cnt, 0);
        for (int i = 0; i < 4; i++) exp_prev[i] = 8'h00;

        run_xfer(3, 8'h81, 8'h00, 1'b1, 8'h81, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish_before_1ms");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
- Parameterised SPI bus master: one full-duplex, MSB-first transfer of DATA_WIDTH bits per start pulse.
- Supports all four CPOL/CPHA modes.
- Sits between a local controller (parallel data_in/data_out, start/finish handshake) and a single SPI slave; drives spi_clk, cs_n and mosi, samples miso.
- The SPI clock is derived from the system clock by an integer divider.

Parameters:
- CLK_FREQUENCE, 50_000_000: system clock frequency in Hz.
- SPI_FREQUENCE, 5_000_000: target SPI clock frequency in Hz.
- DATA_WIDTH, 8: bits per transfer.
- CPOL, 1: idle level of spi_clk.
- CPHA, 1: 0 = sample on leading edge, 1 = sample on trailing edge.

Ports:
- sclk  input  1  system clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-high reset.
- data_in  input  DATA_WIDTH  transmit word; captured when start is accepted.
- start  input  1  transfer request, sampled high for one or more cycles while idle.
- miso  input  1  serial data from slave.
- spi_clk  output  1  SPI serial clock.
- cs_n  output  1  active-low slave select.
- mosi  output  1  serial data to slave, MSB first.
- finish  output  1  one-cycle pulse at transfer end.
- data_out  output  DATA_WIDTH  last received word; valid from the finish cycle and held until the next finish.

Behaviour:
- Reset is decided: reset rst_n, asynchronous, active-high; clock sclk.
- Reset values: spi_clk=CPOL, cs_n=1, mosi=0, finish=0, data_out=0, state IDLE, counters 0.
- Reset asserted mid-transfer aborts immediately to the reset values; no finish pulse is produced.
- HALF = CLK_FREQUENCE/(2*SPI_FREQUENCE), integer floor; 5 at the defaults. HALF must be at least 1; elaboration error otherwise.
- Leading edge = spi_clk leaving CPOL; trailing edge = spi_clk returning to CPOL.
- States: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - Outputs as after reset.
  - start=1 at a rising sclk edge (cycle T0) loads data_in into the TX shift register, clears the RX register, moves to SHIFT.
  - From T1: cs_n=0.
  - CPHA=0: mosi = MSB from T1.
  - CPHA=1: mosi stays 0 until the first leading edge.
- SHIFT:
  - Half-period counter counts HALF cycles.
  - A toggle of spi_clk occurs at T1+k*HALF for k=1..2*DATA_WIDTH.
  - CPHA=0: miso is sampled into the RX LSB (shift left) on each leading edge; on each trailing edge except the last, mosi advances to the next bit.
  - CPHA=1: mosi advances to the next bit (first = MSB) on each leading edge; miso is sampled on each trailing edge.
  - After the 2*DATA_WIDTH-th toggle, spi_clk is back at CPOL.
- DONE:
  - Entered HALF cycles after the last toggle (T1+(2*DATA_WIDTH+1)*HALF; T1+85 at the defaults).
  - In that cycle: cs_n=1, mosi=0, finish=1 for exactly one cycle, data_out=RX register. Then IDLE.
- start during SHIFT/DONE is ignored (no queuing).
- start sampled in the cycle after finish is accepted, which allows back-to-back transfers.
- data_in changes after T0 do not affect the transfer in progress.
- The last miso sample and data_out update use the bit captured on the final sample edge. The final sample lands on toggle 2*DATA_WIDTH-1 (CPHA=0) or toggle 2*DATA_WIDTH (CPHA=1).

Decomposition:
- Shared package spi_pkg: state enum (IDLE, SHIFT, DONE) and a constant function computing HALF from the two frequencies.
- One sub-module, spi_clk_gen: half-period counter plus edge counter. It emits leading/trailing strobes and a last-edge flag to the FSM, and drives spi_clk.
- FSM and shift registers stay in spi_master.

Test Plan:
- Defaults (mode 3), miso looped from mosi, data_in=0xA5, start one cycle -> cs_n low exactly 85 sclk cycles; 16 spi_clk toggles at 5-cycle spacing, idle high; single finish pulse; data_out=0xA5.
- Back-to-back: start one cycle after the first finish with data_in=0x9A -> second transfer begins at T1; data_out=0x9A; data_out holds 0xA5 in between.
- CPOL=0/CPHA=0, slave model shifts out 0x3C on trailing edges, data_in=0xC3 -> mosi carries 1,1,0,0,0,0,1,1 valid at each rising edge; data_out=0x3C.
- CPOL=1/CPHA=0 and CPOL=0/CPHA=1 loopback with 0x5A -> data_out=0x5A; spi_clk idle level equals CPOL before and after the transfer.
- start held high for 40 cycles mid-transfer -> ignored; exactly one finish pulse; no restart.
- rst_n asserted at toggle 7 -> cs_n=1, spi_clk=CPOL, mosi=0 immediately, no finish; after release a new start completes normally.
